// File: rtl/fetch_queue_if.sv
// Fetch->decode and fetch->I-cache signal bundle. Trailing underscore marks active-low strobes.
interface fetch_queue_if #(
  parameter int ADDR = 32,
  parameter int INST = 32
);
  logic            ic_req_;
  logic [ADDR-1:0] ic_addr;
  logic            ic_ack_;
  logic [INST-1:0] ic_inst;
  logic            br_redirect_;
  logic [ADDR-1:0] br_target;
  logic            inst_e_;
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;
  logic            dec_stall;

  modport master (
    output ic_req_, ic_addr, inst_e_, inst_pc, inst,
    input  ic_ack_, ic_inst, br_redirect_, br_target, dec_stall
  );

  modport slave (
    input  ic_req_, ic_addr, inst_e_, inst_pc, inst,
    output ic_ack_, ic_inst, br_redirect_, br_target, dec_stall
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential-PC fetcher: one outstanding I-cache request, returned (pc, inst) pairs
// buffered in a DEPTH-entry FIFO toward decode; a branch redirect flushes and restarts.
module fetch_queue #(
  parameter int              ADDR     = 32,
  parameter int              INST     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master fq
);
  localparam int              PW   = $clog2(DEPTH);
  localparam logic [ADDR-1:0] STEP = ADDR'(INST / 8);
  localparam logic [PW:0]     FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e                            state_q;
  logic                              ic_req_q;
  logic [ADDR-1:0]                   ic_addr_q;
  logic [ADDR-1:0]                   fetch_pc_q;
  logic [DEPTH-1:0][ADDR+INST-1:0]   mem_q;
  logic [PW-1:0]                     wr_ptr_q, rd_ptr_q;
  logic [PW:0]                       count_q, count_d;

  logic redir, ack, push, pop;

  assign redir = ~fq.br_redirect_;
  assign ack   = ~fq.ic_ack_;
  assign pop   = (count_q != '0) && !fq.dec_stall && !redir;
  assign push  = (state_q == REQ) && ack && !redir;

  always_comb begin
    count_d = count_q;
    if (redir) count_d = '0;
    else begin
      if (push) count_d = count_d + (PW + 1)'(1);
      if (pop)  count_d = count_d - (PW + 1)'(1);
    end
  end

  // FIFO storage and pointers; a redirect wins over any same-cycle push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (redir) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= {fetch_pc_q, fq.ic_inst};
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ic_req_q   <= 1'b1;
      ic_addr_q  <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redir) fetch_pc_q <= fq.br_target;
          else if (count_q < FULL) begin
            state_q   <= REQ;
            ic_req_q  <= 1'b0;
            ic_addr_q <= fetch_pc_q;
          end
        end
        REQ: begin
          if (redir) begin
            fetch_pc_q <= fq.br_target;
            if (ack) begin
              state_q  <= IDLE;
              ic_req_q <= 1'b1;
            end else begin
              // Request already issued: let it complete, then throw the data away.
              state_q <= DROP;
            end
          end else if (ack) begin
            fetch_pc_q <= fetch_pc_q + STEP;
            if (count_d < FULL) ic_addr_q <= fetch_pc_q + STEP;
            else begin
              state_q  <= IDLE;
              ic_req_q <= 1'b1;
            end
          end
        end
        DROP: begin
          if (redir) fetch_pc_q <= fq.br_target;
          if (ack) begin
            state_q  <= IDLE;
            ic_req_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          ic_req_q <= 1'b1;
        end
      endcase
    end
  end

  assign fq.ic_req_            = ic_req_q;
  assign fq.ic_addr            = ic_addr_q;
  assign fq.inst_e_            = (count_q == '0);
  assign {fq.inst_pc, fq.inst} = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded bench for fetch_queue: a bench-side I-cache responder pushes expected
// (pc, inst) pairs when it acks; the decode side pops and compares them.
module tb_fetch_queue;
  localparam int ADDR  = 32;
  localparam int INST  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR(ADDR), .INST(INST)) fq ();

  fetch_queue #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc = '0;
  logic [31:0] drop_addr = '0;
  bit          drop_pend = 1'b0;
  bit          ack_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: check outputs, drive this cycle's inputs, advance to the next negedge.
  task automatic cyc(input bit redir = 1'b0, input logic [31:0] tgt = '0);
    bit          acked = 1'b0;
    logic [31:0] d;
    chk("empty", 64'(fq.inst_e_), 64'(exp_q.size() == 0));
    if (!fq.inst_e_ && exp_q.size() > 0) begin
      chk("head", {fq.inst_pc, fq.inst}, exp_q[0]);
      if (!fq.dec_stall && !redir) void'(exp_q.pop_front());
    end
    if (!fq.ic_req_ && drop_pend) chk("drop_addr", 64'(fq.ic_addr), 64'(drop_addr));
    if (!fq.ic_req_ && ack_en) begin
      d = $urandom;
      fq.ic_ack_ = 1'b0;
      fq.ic_inst = d;
      acked = 1'b1;
      if (drop_pend) drop_pend = 1'b0;
      else begin
        chk("req_addr", 64'(fq.ic_addr), 64'(model_pc));
        if (!redir) exp_q.push_back({model_pc, d});
        model_pc += 32'd4;
      end
    end else begin
      fq.ic_ack_ = 1'b1;
      fq.ic_inst = '0;
    end
    fq.br_redirect_ = !redir;
    fq.br_target    = tgt;
    if (redir) begin
      exp_q.delete();
      if (!fq.ic_req_ && !acked) begin
        if (!drop_pend) drop_addr = model_pc;
        drop_pend = 1'b1;
      end
      model_pc = tgt;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fq.ic_ack_ = 1'b1;
    fq.br_redirect_ = 1'b1;
    exp_q.delete();
    model_pc = '0;
    drop_pend = 1'b0;
    #1;
    chk("rst_req", 64'(fq.ic_req_), 64'd1);
    chk("rst_addr", 64'(fq.ic_addr), 64'd0);
    chk("rst_e", 64'(fq.inst_e_), 64'd1);
    chk("rst_pc", 64'(fq.inst_pc), 64'd0);
    chk("rst_inst", 64'(fq.inst), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_to(input int n, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == n) break;
      cyc();
    end
    chk(tag, 64'(exp_q.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fq.ic_ack_ = 1'b1;
    fq.ic_inst = '0;
    fq.br_redirect_ = 1'b1;
    fq.br_target = '0;
    fq.dec_stall = 1'b0;
    @(negedge clk);

    // Reset release and first request
    do_reset();
    ack_en = 1'b0;
    cyc();
    chk("t1_req", 64'(fq.ic_req_), 64'd0);
    chk("t1_addr", 64'(fq.ic_addr), 64'd0);
    chk("t1_e", 64'(fq.inst_e_), 64'd1);
    cyc();
    chk("t1_e_still", 64'(fq.inst_e_), 64'd1);

    // Streaming, one instruction per cycle
    ack_en = 1'b1;
    repeat (10) cyc();

    // Backpressure fills the FIFO, then drains
    do_reset();
    fq.dec_stall = 1'b1;
    repeat (8) cyc();
    chk("t3_idle", 64'(fq.ic_req_), 64'd1);
    chk("t3_head", 64'(fq.inst_pc), 64'd0);
    fq.dec_stall = 1'b0;
    repeat (10) cyc();

    // Redirect while a request is outstanding
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (model_pc == 32'h8) break;
      cyc();
    end
    chk("t4_reach", 64'(model_pc), 64'h8);
    ack_en = 1'b0;
    cyc();
    cyc(1'b1, 32'h100);
    chk("t4_e", 64'(fq.inst_e_), 64'd1);
    chk("t4_addr", 64'(fq.ic_addr), 64'h8);
    repeat (2) cyc();
    ack_en = 1'b1;
    repeat (8) cyc();

    // Redirect + ack + pop in one cycle with two entries queued
    do_reset();
    fq.dec_stall = 1'b1;
    fill_to(2, "t5_reach");
    fq.dec_stall = 1'b0;
    cyc(1'b1, 32'h200);
    chk("t5_e", 64'(fq.inst_e_), 64'd1);
    chk("t5_idle", 64'(fq.ic_req_), 64'd1);
    repeat (8) cyc();

    // PC wraps silently past all-ones
    cyc(1'b1, 32'hFFFF_FFF8);
    repeat (8) cyc();

    // Reset asserted while dropping a stale request after a queue was built
    do_reset();
    fq.dec_stall = 1'b1;
    fill_to(3, "t6_reach");
    ack_en = 1'b0;
    cyc();
    cyc(1'b1, 32'h300);
    chk("t6_drop", 64'(fq.ic_req_), 64'd0);
    do_reset();
    fq.dec_stall = 1'b0;
    ack_en = 1'b1;
    cyc();
    chk("t6_restart", 64'(fq.ic_addr), 64'd0);
    repeat (8) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
